rst_sequencer: RTL and testbench

Board-level reset sequencer that generates the per-domain asynchronous reset requests consumed by the per-domain two-flop reset synchronizers. It holds every downstream domain in reset until the PLL is locked and the reset pushbutton is released and debounced. It then waits a fixed hold time and releases the domains one at a time in a fixed order, with a fixed gap between releases. Any loss of lock or any debounced button press during operation collapses all domains back into reset.

---
 rtl/rst_seq_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/rst_sequencer.sv | 132 +++++++++++++
 tb/tb_rst_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and default timing constants for the board reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RELEASE   = 2'd3
    } rst_state_e;

    localparam int unsigned DEF_N_STAGES        = 3;
    localparam int unsigned DEF_HOLD_CYCLES     = 1024;
    localparam int unsigned DEF_STAGE_GAP       = 16;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 65536;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((64'(1) << w) <= 64'(max_val))) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer; o_q flips only
// after the synchronized input has differed from it for CYCLES consecutive cycles.
module btn_debounce
    import rst_seq_pkg::*;
#(
    parameter int unsigned CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    localparam int unsigned CNT_W = cnt_width(CYCLES);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    always_comb begin
        sync_d = {sync_q[0], i_d};
        cnt_d  = '0;
        db_d   = db_q;
        // Any sample matching the current state restarts the stability count.
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_W'(CYCLES - 1)) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign o_q = db_q;

endmodule

// File: rtl/rst_sequencer.sv
// Board reset sequencer: holds all domains in reset until lock and a released
// button, waits a hold time, then releases domains one by one in thermometer order.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_STAGES        = DEF_N_STAGES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned STAGE_GAP       = DEF_STAGE_GAP,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pll_locked,
    input  logic                i_btn_n,
    output logic [N_STAGES-1:0] o_rstn,
    output logic                o_ready,
    output logic [1:0]          o_state
);

    localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int unsigned GAP_W  = cnt_width(STAGE_GAP);

    logic [1:0]          lock_sync_q, lock_sync_d;
    logic                lock_s;
    logic                btn_press;
    logic                btn_db;
    logic                abort;

    rst_state_e          state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [N_STAGES-1:0] rstn_q, rstn_d;
    logic                ready_q, ready_d;

    assign btn_press = ~i_btn_n;

    btn_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (btn_press),
        .o_q   (btn_db)
    );

    always_comb begin
        lock_sync_d = {lock_sync_q[0], i_pll_locked};
    end

    assign lock_s = lock_sync_q[1];
    assign abort  = ~lock_s | btn_db;

    // Next-state and counter logic; abort outranks any terminal count.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rstn_d     = rstn_q;
        ready_d    = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
                rstn_d  = '0;
            end
            ST_WAIT_LOCK: begin
                hold_cnt_d = '0;
                gap_cnt_d  = '0;
                rstn_d     = '0;
                if (lock_s && !btn_db) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d    = ST_WAIT_LOCK;
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                    rstn_d     = '0;
                end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d   = ST_RELEASE;
                    gap_cnt_d = '0;
                    rstn_d    = N_STAGES'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (abort) begin
                    state_d    = ST_WAIT_LOCK;
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                    rstn_d     = '0;
                end else if (&rstn_q) begin
                    ready_d = 1'b1;
                end else if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
                    rstn_d    = (rstn_q << 1) | N_STAGES'(1);
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_RESET;
                rstn_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_sync_q <= '0;
            state_q     <= ST_RESET;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            rstn_q      <= '0;
            ready_q     <= 1'b0;
        end else begin
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rstn_q      <= rstn_d;
            ready_q     <= ready_d;
        end
    end

    assign o_rstn  = rstn_q;
    assign o_ready = ready_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with small timing parameters and hand-computed timelines.
module tb_rst_sequencer;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       btn_n;
    logic [2:0] rstn;
    logic       ready;
    logic [1:0] state;

    int n_cmp;
    int n_err;

    rst_sequencer #(
        .N_STAGES        (3),
        .HOLD_CYCLES     (8),
        .STAGE_GAP       (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pll_locked (lock),
        .i_btn_n      (btn_n),
        .o_rstn       (rstn),
        .o_ready      (ready),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Timeline from the moment lock_s/btn_db conditions are driven good (edge 0):
    // lock_s valid at edge 2, HOLD at edge 3, releases at 11/15/19, ready at 20.
    task automatic expect_boot(input string tag);
        tick(2);
        check({tag, ".wait_state"}, 32'(state), 32'd1);
        check({tag, ".wait_rstn"},  32'(rstn),  32'b000);
        tick(1);
        check({tag, ".hold_state"}, 32'(state), 32'd2);
        tick(7);
        check({tag, ".hold_end_rstn"}, 32'(rstn), 32'b000);
        check({tag, ".hold_end_state"}, 32'(state), 32'd2);
        tick(1);
        check({tag, ".rel0_rstn"},  32'(rstn),  32'b001);
        check({tag, ".rel0_state"}, 32'(state), 32'd3);
        tick(3);
        check({tag, ".gap0_rstn"},  32'(rstn),  32'b001);
        tick(1);
        check({tag, ".rel1_rstn"},  32'(rstn),  32'b011);
        tick(3);
        check({tag, ".gap1_rstn"},  32'(rstn),  32'b011);
        tick(1);
        check({tag, ".rel2_rstn"},  32'(rstn),  32'b111);
        check({tag, ".rel2_ready"}, 32'(ready), 32'd0);
        tick(1);
        check({tag, ".run_ready"},  32'(ready), 32'd1);
        check({tag, ".run_state"},  32'(state), 32'd3);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        lock  = 1'b1;
        btn_n = 1'b1;

        // Reset values while i_rst is held
        #1;
        check("por_rstn",  32'(rstn),  32'b000);
        check("por_ready", 32'(ready), 32'd0);
        check("por_state", 32'(state), 32'd0);
        tick(5);
        check("rst_hold_state", 32'(state), 32'd0);

        // Clean boot
        rst = 1'b0;
        expect_boot("boot");

        // Short button pulse is filtered out
        btn_n = 1'b0;
        tick(10);
        btn_n = 1'b1;
        check("short_btn_rstn", 32'(rstn), 32'b111);
        tick(30);
        check("short_btn_rstn_late", 32'(rstn),  32'b111);
        check("short_btn_ready",     32'(ready), 32'd1);

        // Long button press: abort 19 edges after the press
        btn_n = 1'b0;
        tick(18);
        check("long_btn_pre_rstn", 32'(rstn), 32'b111);
        tick(1);
        check("long_btn_rstn",  32'(rstn),  32'b000);
        check("long_btn_ready", 32'(ready), 32'd0);
        check("long_btn_state", 32'(state), 32'd1);
        tick(11);
        btn_n = 1'b1;
        // Release debounced at edge 48, HOLD at 49, first release at 57
        tick(18);
        check("btn_rel_wait_state", 32'(state), 32'd1);
        tick(1);
        check("btn_rel_hold_state", 32'(state), 32'd2);
        tick(7);
        check("btn_rel_hold_rstn", 32'(rstn), 32'b000);
        tick(1);
        check("btn_rel_rel0_rstn", 32'(rstn), 32'b001);
        tick(4);
        check("btn_rel_rel1_rstn", 32'(rstn), 32'b011);

        // Lock loss while o_rstn=011
        lock = 1'b0;
        tick(2);
        check("lockloss_pre_rstn", 32'(rstn), 32'b011);
        tick(1);
        check("lockloss_rstn",  32'(rstn),  32'b000);
        check("lockloss_ready", 32'(ready), 32'd0);
        check("lockloss_state", 32'(state), 32'd1);
        lock = 1'b1;
        expect_boot("relock");

        // Lock drop timed to coincide with the HOLD terminal count
        lock = 1'b0;
        tick(3);
        check("sim_abort_state", 32'(state), 32'd1);
        check("sim_abort_rstn",  32'(rstn),  32'b000);
        lock = 1'b1;
        tick(3);
        check("sim_hold_state", 32'(state), 32'd2);
        tick(5);
        lock = 1'b0;
        tick(2);
        check("sim_tc_pre_state", 32'(state), 32'd2);
        tick(1);
        check("sim_tc_state", 32'(state), 32'd1);
        check("sim_tc_rstn",  32'(rstn),  32'b000);
        tick(10);
        check("sim_tc_late_rstn",  32'(rstn),  32'b000);
        check("sim_tc_late_state", 32'(state), 32'd1);

        // Async reset mid-HOLD, applied between clock edges
        lock = 1'b1;
        tick(3);
        check("arst_hold_state", 32'(state), 32'd2);
        tick(2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_hold_state0", 32'(state), 32'd0);
        check("arst_hold_rstn",   32'(rstn),  32'b000);
        check("arst_hold_ready",  32'(ready), 32'd0);
        lock = 1'b0;
        tick(2);
        check("arst_held_state", 32'(state), 32'd0);

        // Late lock: 50 cycles after reset release
        rst = 1'b0;
        tick(1);
        check("late_wait_state", 32'(state), 32'd1);
        tick(49);
        check("late_wait50_state", 32'(state), 32'd1);
        check("late_wait50_rstn",  32'(rstn),  32'b000);
        lock = 1'b1;
        expect_boot("late");

        // Async reset while fully released
        #3;
        rst = 1'b1;
        #1;
        check("arst_run_rstn",  32'(rstn),  32'b000);
        check("arst_run_ready", 32'(ready), 32'd0);
        check("arst_run_state", 32'(state), 32'd0);
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
